// File: rtl/pg_prefix_pipe.sv
// rtl/pg_prefix_pipe.sv - pipelined Kogge-Stone propagate/carry generator
// Optional build macro PG_PREFIX_PIPE_MID_EN adds a register after prefix
// level floor(log2(WIDTH)/2), raising latency from 2 to 3 cycles.
module pg_prefix_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] c,
  output logic             cout
);

  localparam int LEVELS = $clog2(WIDTH);
  // Split point of the prefix tree; used in both builds so results match.
  localparam int MID    = LEVELS / 2;

  // Stage 1: per-bit propagate/generate and carry-in of the accepted beat.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_p_q;
  logic [WIDTH-1:0] s1_g_q;
  logic             s1_cin_q;

  // Output stage.
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_p_q, out_p_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;
  logic             out_cout_q, out_cout_d;

  // Prefix tree halves.
  logic [WIDTH-1:0] front_g, front_p;
  logic [WIDTH-1:0] back_src_g, back_src_p, back_op_p;
  logic             back_cin;
  logic             back_src_valid;
  logic [WIDTH-1:0] back_g, back_p;
  logic [WIDTH-1:0] carry_vec;

  // Handshake: a stage loads when empty or when its contents move on.
  logic load_out;
  logic load_s1;

  assign load_out = !s2_valid_q || out_ready;

`ifdef PG_PREFIX_PIPE_MID_EN
  logic             mid_valid_q, mid_valid_d;
  logic [WIDTH-1:0] mid_g_q, mid_pg_q, mid_p_q;
  logic             mid_cin_q;
  logic             load_mid;

  assign load_mid       = !mid_valid_q || load_out;
  assign load_s1        = !s1_valid_q || load_mid;
  assign back_src_g     = mid_g_q;
  assign back_src_p     = mid_pg_q;
  assign back_op_p      = mid_p_q;
  assign back_cin       = mid_cin_q;
  assign back_src_valid = mid_valid_q;

  // Mid register valid flag follows stage 1 whenever it may load.
  always_comb begin
    mid_valid_d = mid_valid_q;
    if (load_mid) begin
      mid_valid_d = s1_valid_q;
    end
  end

  // Mid register captures the partially reduced (G,P) tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid_valid_q <= 1'b0;
      mid_g_q     <= '0;
      mid_pg_q    <= '0;
      mid_p_q     <= '0;
      mid_cin_q   <= 1'b0;
    end else begin
      mid_valid_q <= mid_valid_d;
      if (load_mid && s1_valid_q) begin
        mid_g_q   <= front_g;
        mid_pg_q  <= front_p;
        mid_p_q   <= s1_p_q;
        mid_cin_q <= s1_cin_q;
      end
    end
  end
`else
  assign load_s1        = !s1_valid_q || load_out;
  assign back_src_g     = front_g;
  assign back_src_p     = front_p;
  assign back_op_p      = s1_p_q;
  assign back_cin       = s1_cin_q;
  assign back_src_valid = s1_valid_q;
`endif

  // in_ready depends only on registered flags and out_ready.
  assign in_ready = load_s1;

  // Stage 1 valid flag next state.
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (load_s1) begin
      s1_valid_d = in_valid;
    end
  end

  // Stage 1 registers; data only captured on an actual transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
      s1_cin_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_valid && load_s1) begin
        s1_p_q   <= a ^ b;
        s1_g_q   <= a & b;
        s1_cin_q <= cin;
      end
    end
  end

  // Prefix levels 0..MID-1: span doubles per level; low bits keep their P.
  always_comb begin
    front_g = s1_g_q;
    front_p = s1_p_q;
    for (int l = 0; l < MID; l++) begin
      front_g = front_g | (front_p & (front_g << (1 << l)));
      front_p = front_p & ((front_p << (1 << l)) | ~({WIDTH{1'b1}} << (1 << l)));
    end
  end

  // Prefix levels MID..LEVELS-1 finish the group (G,P) over [i:0].
  always_comb begin
    back_g = back_src_g;
    back_p = back_src_p;
    for (int l = MID; l < LEVELS; l++) begin
      back_g = back_g | (back_p & (back_g << (1 << l)));
      back_p = back_p & ((back_p << (1 << l)) | ~({WIDTH{1'b1}} << (1 << l)));
    end
  end

  // Carry into bit i+1 is G[i:0] | P[i:0]&cin; bit 0 takes cin directly.
  always_comb begin
    carry_vec  = back_g | (back_p & {WIDTH{back_cin}});
    out_p_d    = back_op_p;
    out_c_d    = {carry_vec[WIDTH-2:0], back_cin};
    out_cout_d = carry_vec[WIDTH-1];
    s2_valid_d = s2_valid_q;
    if (load_out) begin
      s2_valid_d = back_src_valid;
    end
  end

  // Output stage registers; hold last data while empty or stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      out_p_q    <= '0;
      out_c_q    <= '0;
      out_cout_q <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (load_out && back_src_valid) begin
        out_p_q    <= out_p_d;
        out_c_q    <= out_c_d;
        out_cout_q <= out_cout_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign p         = out_p_q;
  assign c         = out_c_q;
  assign cout      = out_cout_q;

endmodule

// File: tb/tb_pg_prefix_pipe.sv
// tb/tb_pg_prefix_pipe.sv - self-checking bench for pg_prefix_pipe
module tb_pg_prefix_pipe;

  localparam int W = 16;
`ifdef PG_PREFIX_PIPE_MID_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] p;
  logic [W-1:0] c;
  logic         cout;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } beat_t;

  beat_t sb[$];
  int    total    = 0;
  int    bad      = 0;
  int    cyc      = 0;
  int    accepted = 0;
  int    released = 0;

  pg_prefix_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .c         (c),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  // One cycle: record transfers decided by the current inputs, then advance.
  task automatic step();
    beat_t       nb;
    beat_t       eb;
    logic [W:0]  esum;
    #1;
    if (in_valid && in_ready) begin
      nb.a = a;
      nb.b = b;
      nb.cin = cin;
      sb.push_back(nb);
      accepted++;
    end
    if (out_valid && out_ready) begin
      released++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat: got p=%h c=%h cout=%b, required no beat", p, c, cout);
      end else begin
        eb = sb.pop_front();
        esum = {1'b0, eb.a} + {1'b0, eb.b} + {{W{1'b0}}, eb.cin};
        if ({cout, p ^ c} !== esum || p !== (eb.a ^ eb.b)) begin
          bad++;
          $display("FAIL beat_sum: got cout/sum=%h p=%h, required %h p=%h",
                   {cout, p ^ c}, p, esum, eb.a ^ eb.b);
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && (sb.size() != 0 || out_valid); k++) step();
    total++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain: %0d beats missing, out_valid=%b, required 0 and 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || p !== '0 || c !== '0 || cout !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b p=%h c=%h cout=%b, required 0 1 0 0 0",
               out_valid, in_ready, p, c, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tc, input logic [W-1:0] ep,
                               input logic [W-1:0] ec, input logic eco);
    int t0;
    bit got;
    out_ready = 1'b1;
    a = ta; b = tb; cin = tc;
    in_valid = 1'b1;
    t0 = cyc;
    step();
    in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      #1;
      if (out_valid) got = 1'b1;
      else step();
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL directed_timeout: no out_valid for a=%h b=%h, required within %0d cycles", ta, tb, LAT);
    end else begin
      if (cyc - t0 != LAT) begin
        bad++;
        $display("FAIL directed_latency: got %0d, required %0d", cyc - t0, LAT);
      end
      total++;
      if (p !== ep || c !== ec || cout !== eco) begin
        bad++;
        $display("FAIL directed_value: got p=%h c=%h cout=%b, required p=%h c=%h cout=%b",
                 p, c, cout, ep, ec, eco);
      end
    end
    step();
    drain();
  endtask

  task automatic test_random();
    int a0;
    int n;
    a0 = accepted;
    n = 0;
    while (accepted - a0 < 1000 && n < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      step();
      n++;
    end
    total++;
    if (accepted - a0 < 1000) begin
      bad++;
      $display("FAIL random_progress: accepted %0d, required 1000", accepted - a0);
    end
    drain();
  endtask

  task automatic test_stall();
    int a0;
    logic [W-1:0] hp, hc;
    logic hco;
    bit moved;
    a0 = accepted;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      step();
    end
    #1;
    total++;
    if (accepted - a0 != LAT) begin
      bad++;
      $display("FAIL stall_accepts: got %0d, required %0d", accepted - a0, LAT);
    end
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_flags: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
    end
    hp = p; hc = c; hco = cout;
    moved = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = W'($urandom); b = W'($urandom);
      step();
      if (p !== hp || c !== hc || cout !== hco || out_valid !== 1'b1) moved = 1'b1;
    end
    total++;
    if (moved) begin
      bad++;
      $display("FAIL stall_stable: got p=%h c=%h cout=%b, required p=%h c=%h cout=%b", p, c, cout, hp, hc, hco);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int r0;
    bit rdy_bad;
    r0 = released;
    rdy_bad = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      #1;
      if (in_ready !== 1'b1) rdy_bad = 1'b1;
      step();
    end
    total++;
    if (rdy_bad || released - r0 != 20 - LAT) begin
      bad++;
      $display("FAIL back_to_back: released %0d ready_drop=%0d, required %0d and 0",
               released - r0, rdy_bad, 20 - LAT);
    end
    drain();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = W'($urandom); b = W'($urandom | 1); cin = 1'b1;
      step();
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL areset_setup: out_valid=%b, required 1", out_valid);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || p !== '0 || c !== '0 || cout !== 1'b0) begin
      bad++;
      $display("FAIL areset_clear: out_valid=%b in_ready=%b p=%h c=%h cout=%b, required 0 1 0 0 0",
               out_valid, in_ready, p, c, cout);
    end
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL areset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 16'h00FF; b = 16'h0101; cin = 1'b1;
    step();
    drain();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a   = '0;
    b   = '0;
    cin = 1'b0;
    test_reset();
    test_directed(16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 16'hFFFE, 1'b1);
    test_directed(16'h8000, 16'h8000, 1'b1, 16'h0000, 16'h0001, 1'b1);
    test_directed(16'h1234, 16'h4321, 1'b0, 16'h5115, 16'h0440, 1'b0);
    test_random();
    test_stall();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
